// File: rtl/parity_serializer_if.sv
// Handshake bundle between a parallel word source and the bit-serial output of
// parity_serializer. The slave modport is the serializer side.
interface parity_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_bit;
    logic              ser_valid;
    logic              ser_last;
    logic              ser_ready;
    logic              busy;

    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_bit, ser_valid, ser_last, busy
    );

    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_bit, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/parity_serializer.sv
// Shifts a parallel word out LSB first over a valid/ready serial port and
// appends its parity bit; the next word may load on the parity transfer.
module parity_serializer #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    parity_serializer_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              par;
    logic              accept;
    logic              xfer;

    assign bus.in_ready  = rst_n && ((state == IDLE) || (state == PAR && bus.ser_ready));
    assign bus.ser_valid = (state != IDLE);
    assign bus.ser_last  = (state == PAR);
    assign bus.busy      = (state != IDLE);
    assign bus.ser_bit   = (state == DATA) ? shreg[0] : ((state == PAR) ? par : 1'b0);

    assign accept = bus.in_valid && bus.in_ready;
    assign xfer   = bus.ser_valid && bus.ser_ready;

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = DATA;
            DATA: if (xfer && cnt == CNT_MAX) state_d = PAR;
            // accept in PAR implies ser_ready, so the parity bit is consumed too
            PAR: begin
                if (accept)    state_d = DATA;
                else if (xfer) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            par   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= bus.in_data;
            par   <= (^bus.in_data) ^ 1'(ODD);
            cnt   <= '0;
        end else if (state == DATA && xfer) begin
            shreg <= {1'b0, shreg[DATA_W-1:1]};
            // saturate on the last data bit so cnt stays within 0..DATA_W-1
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench for parity_serializer: an even-parity and an odd-parity
// instance share clock and reset; each task checks one behaviour inline.
module tb_parity_serializer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    parity_serializer_if #(.DATA_W(8)) bus_e();
    parity_serializer_if #(.DATA_W(8)) bus_o();

    parity_serializer #(.DATA_W(8), .ODD(0)) u_even (.clk(clk), .rst_n(rst_n), .bus(bus_e));
    parity_serializer #(.DATA_W(8), .ODD(1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(bus_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word to one instance and complete the accept edge; returns
    // in the cycle where bit 0 is presented.
    task automatic send_word(input bit sel, input logic [7:0] w);
        int t = 0;
        while (!(sel ? bus_o.in_ready : bus_e.in_ready) && t < 20) begin
            step();
            t++;
        end
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL send_word_timeout: in_ready stayed 0, required 1");
        end
        if (sel) begin bus_o.in_data = w; bus_o.in_valid = 1'b1; end
        else     begin bus_e.in_data = w; bus_e.in_valid = 1'b1; end
        step();
        bus_o.in_valid = 1'b0;
        bus_e.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] exp_f = {1'b0, 8'hA5};
        rst_n = 1'b0;
        step();
        checks++;
        if (bus_e.ser_valid !== 1'b0 || bus_e.in_ready !== 1'b0 || bus_e.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: valid=%b ready=%b busy=%b, required 0 0 0",
                     bus_e.ser_valid, bus_e.in_ready, bus_e.busy);
        end
        rst_n = 1'b1;
        step();
        send_word(1'b0, 8'hA5);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus_e.ser_bit !== exp_f[3] || bus_e.ser_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_bit3: bit=%b valid=%b, required %b 1",
                     bus_e.ser_bit, bus_e.ser_valid, exp_f[3]);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus_e.ser_valid, bus_e.ser_bit, bus_e.ser_last, bus_e.busy, bus_e.in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_midframe: valid,bit,last,busy,ready=%b, required 00000",
                     {bus_e.ser_valid, bus_e.ser_bit, bus_e.ser_last, bus_e.busy, bus_e.in_ready});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus_e.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus_e.in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus_e.ser_valid !== 1'b0 || bus_e.ser_bit !== 1'b0) begin
                errors++;
                $display("FAIL reset_residual[%0d]: valid=%b bit=%b, required 0 0",
                         i, bus_e.ser_valid, bus_e.ser_bit);
            end
            step();
        end
    endtask

    task automatic test_even_parity();
        logic [8:0] exp_f = {1'b0, 8'hA5};
        send_word(1'b0, 8'hA5);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus_e.ser_valid !== 1'b1 || bus_e.ser_bit !== exp_f[i] || bus_e.ser_last !== (i == 8)) begin
                errors++;
                $display("FAIL even_a5[%0d]: valid=%b bit=%b last=%b, required 1 %b %b",
                         i, bus_e.ser_valid, bus_e.ser_bit, bus_e.ser_last, exp_f[i], i == 8);
            end
            step();
        end
        checks++;
        if (bus_e.ser_valid !== 1'b0 || bus_e.busy !== 1'b0) begin
            errors++;
            $display("FAIL even_a5_end: valid=%b busy=%b, required 0 0", bus_e.ser_valid, bus_e.busy);
        end
    endtask

    task automatic test_odd_parity();
        logic [8:0] exp_a = {1'b0, 8'h07};
        logic [8:0] exp_b = {1'b1, 8'h00};
        send_word(1'b1, 8'h07);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus_o.ser_valid !== 1'b1 || bus_o.ser_bit !== exp_a[i] || bus_o.ser_last !== (i == 8)) begin
                errors++;
                $display("FAIL odd_07[%0d]: valid=%b bit=%b last=%b, required 1 %b %b",
                         i, bus_o.ser_valid, bus_o.ser_bit, bus_o.ser_last, exp_a[i], i == 8);
            end
            step();
        end
        send_word(1'b1, 8'h00);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus_o.ser_valid !== 1'b1 || bus_o.ser_bit !== exp_b[i] || bus_o.ser_last !== (i == 8)) begin
                errors++;
                $display("FAIL odd_00[%0d]: valid=%b bit=%b last=%b, required 1 %b %b",
                         i, bus_o.ser_valid, bus_o.ser_bit, bus_o.ser_last, exp_b[i], i == 8);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_s = 12'b000_1111111_00;
        logic [11:0] rdy   = 12'b111_1111000_11;
        send_word(1'b0, 8'h3C);
        for (int i = 0; i < 12; i++) begin
            bus_e.ser_ready = rdy[i];
            #1;
            checks++;
            if (bus_e.ser_valid !== 1'b1 || bus_e.ser_bit !== exp_s[i] || bus_e.ser_last !== (i == 11)
                || bus_e.in_ready !== (i == 11)) begin
                errors++;
                $display("FAIL stall_3c[%0d]: valid=%b bit=%b last=%b ready=%b, required 1 %b %b %b",
                         i, bus_e.ser_valid, bus_e.ser_bit, bus_e.ser_last, bus_e.in_ready,
                         exp_s[i], i == 11, i == 11);
            end
            step();
        end
        bus_e.ser_ready = 1'b1;
        checks++;
        if (bus_e.ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_3c_end: valid=%b, required 0", bus_e.ser_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_s = {1'b0, 8'hFF, 1'b1, 8'h01};
        bus_e.in_data  = 8'h01;
        bus_e.in_valid = 1'b1;
        step();
        bus_e.in_data = 8'hFF;
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (bus_e.ser_valid !== 1'b1 || bus_e.ser_bit !== exp_s[i]
                || bus_e.ser_last !== (i == 8 || i == 17) || bus_e.in_ready !== (i == 8 || i == 17)) begin
                errors++;
                $display("FAIL b2b[%0d]: valid=%b bit=%b last=%b ready=%b, required 1 %b %b %b",
                         i, bus_e.ser_valid, bus_e.ser_bit, bus_e.ser_last, bus_e.in_ready,
                         exp_s[i], i == 8 || i == 17, i == 8 || i == 17);
            end
            step();
            if (i == 8) bus_e.in_valid = 1'b0;
        end
        checks++;
        if (bus_e.ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b, required 0", bus_e.ser_valid);
        end
    endtask

    task automatic test_ignore_busy();
        logic [17:0] exp_s = {1'b0, 8'hC3, 1'b0, 8'h5A};
        send_word(1'b0, 8'h5A);
        for (int i = 0; i < 18; i++) begin
            if (i == 3) begin
                bus_e.in_data  = 8'hC3;
                bus_e.in_valid = 1'b1;
                #1;
                checks++;
                if (bus_e.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready: in_ready=%b, required 0", bus_e.in_ready);
                end
            end
            checks++;
            if (bus_e.ser_valid !== 1'b1 || bus_e.ser_bit !== exp_s[i] || bus_e.ser_last !== (i == 8 || i == 17)) begin
                errors++;
                $display("FAIL busy_frame[%0d]: valid=%b bit=%b last=%b, required 1 %b %b",
                         i, bus_e.ser_valid, bus_e.ser_bit, bus_e.ser_last, exp_s[i], i == 8 || i == 17);
            end
            step();
            if (i == 8) bus_e.in_valid = 1'b0;
        end
        checks++;
        if (bus_e.ser_valid !== 1'b0 || bus_e.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_end: valid=%b busy=%b, required 0 0", bus_e.ser_valid, bus_e.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_e.in_data = '0; bus_e.in_valid = 1'b0; bus_e.ser_ready = 1'b1;
        bus_o.in_data = '0; bus_o.in_valid = 1'b0; bus_o.ser_ready = 1'b1;
        step();
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_backpressure();
        test_back_to_back();
        test_ignore_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_serializer.md
# parity_serializer

Bit-serial transmit stage that feeds a single-bit XOR/parity datapath. It accepts a parallel word over a valid/ready handshake and shifts the word out LSB first, one bit per accepted cycle. It then appends a parity bit computed as the XOR reduction of the word. It sits between a parallel word source and any serial consumer, such as a line driver or a downstream XOR-based checker.

## Interface
Parameters:
- DATA_W, default 8: word width in bits; legal range 2..32.
- ODD, default 0: parity mode. 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising clk edge.
- in_data, input, DATA_W: parallel word; sampled only on an accept.
- in_valid, input, 1: upstream word available.
- in_ready, output, 1: block can accept a word this cycle.
- ser_bit, output, 1: current serial bit.
- ser_valid, output, 1: ser_bit is meaningful.
- ser_last, output, 1: high only while the parity bit is presented.
- ser_ready, input, 1: downstream consumes ser_bit this cycle.
- busy, output, 1: high in DATA or PAR states.

## Operation
- Accept: occurs when in_valid && in_ready at a clock edge. On accept:
  - shreg <= in_data, par <= ^in_data ^ ODD, cnt <= 0, state <= DATA.
- Transfer: occurs when ser_valid && ser_ready at a clock edge.
- States:
  - IDLE: ser_valid=0, ser_bit=0, ser_last=0, in_ready=1.
  - DATA: ser_valid=1, ser_bit=shreg[0]. On transfer: shreg shifts right (zero fill) and cnt increments. When cnt==DATA_W-1 at transfer, go to PAR.
  - PAR: ser_valid=1, ser_bit=par, ser_last=1. On transfer without a simultaneous accept, go to IDLE.
- in_ready = (state==IDLE) || (state==PAR && ser_ready), gated low while rst_n=0. in_ready is combinational from state and ser_ready.
- Simultaneous last transfer and accept in PAR: the new word loads and state goes directly to DATA, with no idle bubble.
- Stall: while ser_valid && !ser_ready, ser_bit, ser_last, shreg, cnt and par hold. No bit is ever skipped or duplicated.
- in_valid while in_ready=0 is ignored; the in-flight word is unaffected.
- cnt width is clog2(DATA_W). cnt never exceeds DATA_W-1 and resets to 0 on each accept.
- Reset (rst_n=0 at an edge, including mid-frame):
  - state=IDLE, shreg=0, par=0, cnt=0.
  - Outputs ser_valid=0, ser_bit=0, ser_last=0, busy=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
  - A partially sent frame is discarded; nothing resumes after reset.

## Timing
- Latency: word accepted at edge N → bit 0 on ser_bit during cycle N+1 (all serial outputs are registered).
- With ser_ready held high: bit i is presented in cycle N+1+i, and parity in cycle N+1+DATA_W.
- Frame length is DATA_W+1 transfers.
- Back-to-back throughput: one word per DATA_W+1 cycles, with ser_valid continuously high.
- Each stall cycle extends the frame by exactly one cycle.
- ser_ready is never required to be high for the block to accept from IDLE.

## Test plan
- Reset: assert rst_n=0 during bit 3 of a frame. Required: next cycle ser_valid=0, ser_bit=0, ser_last=0, busy=0, in_ready=0. After release, in_ready=1 and no residual bits appear.
- Even parity (ODD=0, DATA_W=8): 0xA5 with ser_ready=1. Required: ser_bit sequence 1,0,1,0,0,1,0,1 then parity 0, ser_last=1 on the 9th cycle only.
- Odd parity (ODD=1): 0x07. Required: bits 1,1,1,0,0,0,0,0 then parity 0. Then 0x00, required parity 1.
- Backpressure: 0x3C with ser_ready low for 3 cycles while bit 2 is presented. Required: bit 2 (=1) holds for 4 cycles, the sequence is otherwise 0,0,1,1,1,1,0,0 plus parity 0, and the frame ends after 12 cycles.
- Back-to-back: 0x01 then 0xFF with in_valid held high and ser_ready=1. Required:
  - 18 consecutive ser_valid cycles: bits 1,0,0,0,0,0,0,0, parity 1, then eight 1s, parity 0.
  - The second accept coincides with the first parity transfer.
- Ignore during busy: change in_data and pulse in_valid mid-frame. Required: in_ready=0, the frame is transmitted unaltered, and the new word is accepted only in PAR or IDLE.
